// File: rtl/sram_bist_checker_pkg.sv
// Shared types for the SRAM BIST checker: checker FSM state encoding.
package bist_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } checker_state_t;

endpackage

// File: rtl/read_expect_pipe.sv
// Fixed-depth delay line for expected-read entries; the MSB of each entry is its valid bit.
module read_expect_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    logic [DEPTH-1:0][WIDTH-1:0] stage;

    // Shifts unconditionally so in-flight reads are never stalled.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            stage <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) busy = busy | stage[i][WIDTH-1];
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/sram_bist_checker.sv
// Forwards patgen requests to the SRAM, delays expected data by the read latency and scores mismatches.
module sram_bist_checker
    import bist_checker_pkg::*;
#(
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int MASK_WIDTH    = 4,
    parameter int READ_LATENCY  = 1,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     en,
    output logic                     pg_en,
    input  logic [ADDR_WIDTH-1:0]    pg_addr,
    input  logic [DATA_WIDTH-1:0]    pg_data,
    input  logic [DATA_WIDTH-1:0]    pg_check,
    input  logic [MASK_WIDTH-1:0]    pg_wmask,
    input  logic                     pg_we,
    input  logic                     pg_re,
    input  logic                     pg_done,
    output logic                     sram_ce,
    output logic                     sram_we,
    output logic [ADDR_WIDTH-1:0]    sram_addr,
    output logic [DATA_WIDTH-1:0]    sram_din,
    output logic [MASK_WIDTH-1:0]    sram_wmask,
    input  logic [DATA_WIDTH-1:0]    sram_dout,
    output logic                     done,
    output logic                     fail,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic                     first_fail_valid,
    output logic [ADDR_WIDTH-1:0]    first_fail_addr,
    output logic [DATA_WIDTH-1:0]    first_fail_data
);

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] check;
    } expect_entry_t;

    checker_state_t state, state_next;
    expect_entry_t  pipe_in, pipe_out;
    logic           pipe_busy;
    logic           issue;
    logic           mismatch;

    // A simultaneous write+read is a write; only pure reads queue a check.
    always_comb begin
        pg_en      = en & ((state == IDLE) | (state == RUN));
        issue      = pg_en & ~pg_done & (pg_we | pg_re);
        sram_ce    = issue;
        sram_we    = issue & pg_we;
        sram_addr  = pg_addr;
        sram_din   = pg_data;
        sram_wmask = sram_we ? pg_wmask : '0;
        pipe_in    = '{valid: issue & pg_re & ~pg_we, addr: pg_addr, check: pg_check};
        mismatch   = pipe_out.valid & (sram_dout != pipe_out.check);
    end

    read_expect_pipe #(
        .DEPTH (READ_LATENCY),
        .WIDTH ($bits(expect_entry_t))
    ) u_pipe (
        .clk  (clk),
        .rstb (rstb),
        .d    (pipe_in),
        .q    (pipe_out),
        .busy (pipe_busy)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en) state_next = RUN;
            RUN:     if (en && pg_done) state_next = DRAIN;
            DRAIN:   if (!pipe_busy) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state_next == DONE);
        end
    end

    // First-failure capture is write-once until reset.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            fail             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_addr  <= '0;
            first_fail_data  <= '0;
        end else if (mismatch) begin
            fail <= 1'b1;
            if (err_count != '1) err_count <= err_count + ERR_CNT_WIDTH'(1);
            if (!first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_addr  <= pipe_out.addr;
                first_fail_data  <= sram_dout ^ pipe_out.check;
            end
        end
    end

endmodule
